motor_drive: RTL and testbench
==============================

# motor_drive

Converts the obstacle-avoidance FSM's drive commands (stop, backward, turn_left, turn_right) into per-wheel H-bridge controls: PWM enable plus direction for the left and right motors. It sits between the turn controller and the motor driver pins. It enforces a coast dead-time on every direction reversal and a soft-start duty ramp, so the bridge never sees a hard reversal.

## Interface
- PWM_PERIOD, 1000: PWM period in clk_1M cycles (1 kHz); legal range 2..65535.
- DUTY_FWD, 700: target duty for FORWARD, in cycles high per period.
- DUTY_BACK, 500: target duty for REVERSE.
- DUTY_TURN, 600: target duty, both wheels, for LEFT/RIGHT pivots.
- RAMP_STEP, 100: duty increment per PWM period while ramping up.
- DEAD_TIME, 2000: coast cycles before any direction change.
- clk_1M  input  1  system clock, 1 MHz.
- rst  input  1  reset; synchronous, active-high.
- stop  input  1  halt request.
- backward  input  1  reverse request; meaningful only with stop=1.
- turn_left  input  1  pivot-left request.
- turn_right  input  1  pivot-right request.
- pwm_l, pwm_r  output  1 each  bridge enable, left/right motor.
- dir_l, dir_r  output  1 each  1 = forward, 0 = reverse.
- mode  output  3  applied mode: 0 HALT, 1 FORWARD, 2 REVERSE, 3 LEFT, 4 RIGHT.
- busy  output  1  high while dead-time is running.

## Operation
- Decode priority, top wins:
  - stop&backward -> REVERSE.
  - stop -> HALT; turn inputs are ignored.
  - turn_left&turn_right -> HALT.
  - turn_left -> LEFT.
  - turn_right -> RIGHT.
  - otherwise -> FORWARD.
- Decode output is registered into tgt_mode, giving 1 cycle of latency.
- Direction and target duty per mode:
  - FORWARD: dir_l=1, dir_r=1, DUTY_FWD.
  - REVERSE: dir_l=0, dir_r=0, DUTY_BACK.
  - LEFT: dir_l=0, dir_r=1, DUTY_TURN.
  - RIGHT: dir_l=1, dir_r=0, DUTY_TURN.
  - HALT: directions hold their current values; target duty is 0.
- FSM states:
  - RUN: if tgt_mode requires a dir_l or dir_r different from the current value, go to DEAD. In the same cycle, force both active duties to 0, reload the dead counter, and assert busy.
  - DEAD: pwm_l=pwm_r=0 and directions are held. The counter decrements every cycle. When it reaches 0, dir_l/dir_r take the directions of the current tgt_mode (not the mode that caused entry), mode updates, busy drops, and the FSM returns to RUN with active duties at 0.
- A command change during DEAD does not restart or shorten the dead time.
- With no direction change, mode updates immediately in RUN.
- Ramp, evaluated only at a period boundary (pwm_cnt == PWM_PERIOD-1), per wheel:
  - If active < target: active = min(active+RAMP_STEP, target).
  - If active > target: active = target (deceleration is immediate).
- PWM:
  - pwm_cnt runs 0..PWM_PERIOD-1 and wraps; it is free-running and never resets except on rst.
  - pwm_x = (pwm_cnt < active_x), registered.
  - active_x = 0 gives constant low; active_x = PWM_PERIOD gives constant high.
- Widths: counters and duties are 16-bit unsigned. Ramp addition saturates at target and must not wrap.

## Timing
- Reset values, one cycle after rst is sampled high:
  - pwm_l=pwm_r=0.
  - dir_l=dir_r=1.
  - mode=0 (HALT).
  - busy=0.
  - pwm_cnt=0, active duties 0, tgt_mode HALT.
- rst asserted mid-DEAD or mid-ramp aborts immediately to the reset state. No dead-time is owed after reset, because the bridge is already coasting.
- Command to tgt_mode takes 1 cycle. tgt_mode to busy/DEAD entry takes 1 cycle. The pwm outputs are low no later than 2 cycles after the input change.
- A duty change with no direction change first appears at the next pwm_cnt == 0.
- Dead-time: busy is high for exactly DEAD_TIME cycles. The dir outputs change in the same cycle that busy falls.
- A command pulse shorter than 1 cycle is not guaranteed to be seen. Commands are level-held by the turn controller, with a minimum hold of 1 s.

## Test plan
- Reset, then FORWARD (all inputs 0):
  - mode=1 2 cycles later.
  - active duty 100,200,…,700 over 7 successive periods, then constant.
  - pwm_l high for exactly 700 of every 1000 cycles.
- FORWARD steady, then stop=1:
  - mode=0 with no busy.
  - pwm low from the next period onward.
  - dir_l, dir_r stay 1.
- FORWARD steady, then stop=1, backward=1:
  - busy high for exactly 2000 cycles with pwm_l=pwm_r=0.
  - dir_l, dir_r go to 0 as busy falls.
  - duty ramps 100→500.
- FORWARD, then turn_left=1:
  - dead-time runs; dir_l=0 and dir_r=1 afterwards.
  - both duties ramp to 600.
- During DEAD (FORWARD→REVERSE), switch the inputs to turn_right=1 at cycle 500:
  - busy still ends at cycle 2000.
  - final dir_l=1, dir_r=0, mode=4.
- Other cases:
  - stop=1 with turn_left=1 → HALT, no dead-time.
  - turn_left=turn_right=1 → HALT.
  - rst asserted at dead-time cycle 1000 → reset values on the next cycle, busy=0.

Source files
------------

// File: rtl/motor_drive.sv
// -----------------------------------------------------------------------------
// motor_drive
//
// Purpose:
//   Turns the obstacle-avoidance FSM's level commands into per-wheel H-bridge
//   controls (PWM enable + direction). Every direction reversal is preceded by
//   a coast dead-time, and duty ramps up in RAMP_STEP increments once per PWM
//   period, so the bridge never sees a hard reversal.
//
// Ports:
//   clk_1M      in   system clock, 1 MHz
//   rst         in   synchronous, active-high reset
//   stop        in   halt request (with backward: reverse)
//   backward    in   reverse request, only meaningful with stop=1
//   turn_left   in   pivot-left request
//   turn_right  in   pivot-right request
//   pwm_l/pwm_r out  bridge enable, left/right motor (registered)
//   dir_l/dir_r out  1 = forward, 0 = reverse (registered)
//   mode        out  applied mode: 0 HALT, 1 FORWARD, 2 REVERSE, 3 LEFT, 4 RIGHT
//   busy        out  high while dead-time is running
// -----------------------------------------------------------------------------
module motor_drive #(
  parameter int unsigned PWM_PERIOD = 1000,
  parameter int unsigned DUTY_FWD   = 700,
  parameter int unsigned DUTY_BACK  = 500,
  parameter int unsigned DUTY_TURN  = 600,
  parameter int unsigned RAMP_STEP  = 100,
  parameter int unsigned DEAD_TIME  = 2000
) (
  input  logic       clk_1M,
  input  logic       rst,
  input  logic       stop,
  input  logic       backward,
  input  logic       turn_left,
  input  logic       turn_right,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic [2:0] mode,
  output logic       busy
);

  localparam logic [2:0] MODE_HALT = 3'd0;
  localparam logic [2:0] MODE_FWD  = 3'd1;
  localparam logic [2:0] MODE_REV  = 3'd2;
  localparam logic [2:0] MODE_LEFT = 3'd3;
  localparam logic [2:0] MODE_RGHT = 3'd4;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DEAD = 1'b1;

  localparam logic [15:0] PERIOD_LAST = 16'(PWM_PERIOD - 1);
  localparam logic [15:0] DUTY_FWD_W  = 16'(DUTY_FWD);
  localparam logic [15:0] DUTY_BACK_W = 16'(DUTY_BACK);
  localparam logic [15:0] DUTY_TURN_W = 16'(DUTY_TURN);
  localparam logic [15:0] STEP_W      = 16'(RAMP_STEP);
  // The counter runs DEAD_TIME-1 down to 0 so busy is high for exactly
  // DEAD_TIME cycles, including the exit cycle.
  localparam logic [15:0] DEAD_LOAD   = 16'(DEAD_TIME - 1);

  // Command decode, top entry wins.
  function automatic logic [2:0] decode_cmd(input logic s, input logic b,
                                            input logic tl, input logic tr);
    logic [2:0] m;
    if (s && b)        m = MODE_REV;
    else if (s)        m = MODE_HALT;
    else if (tl && tr) m = MODE_HALT;
    else if (tl)       m = MODE_LEFT;
    else if (tr)       m = MODE_RGHT;
    else               m = MODE_FWD;
    return m;
  endfunction

  // Wheel directions required by a mode; HALT keeps whatever is applied now.
  function automatic logic [1:0] mode_dirs(input logic [2:0] m,
                                           input logic cur_l, input logic cur_r);
    logic [1:0] d;
    case (m)
      MODE_FWD:  d = 2'b11;
      MODE_REV:  d = 2'b00;
      MODE_LEFT: d = 2'b01;
      MODE_RGHT: d = 2'b10;
      default:   d = {cur_l, cur_r};
    endcase
    return d;
  endfunction

  // Target duty for a mode, identical for both wheels.
  function automatic logic [15:0] mode_duty(input logic [2:0] m);
    logic [15:0] t;
    case (m)
      MODE_FWD:  t = DUTY_FWD_W;
      MODE_REV:  t = DUTY_BACK_W;
      MODE_LEFT: t = DUTY_TURN_W;
      MODE_RGHT: t = DUTY_TURN_W;
      default:   t = 16'd0;
    endcase
    return t;
  endfunction

  // One ramp step: climb by STEP without passing the target, drop at once.
  // The headroom compare avoids forming act+STEP, which could wrap.
  function automatic logic [15:0] ramp(input logic [15:0] act,
                                       input logic [15:0] tgt);
    logic [15:0] r;
    if (act < tgt) begin
      if ((tgt - act) > STEP_W) r = act + STEP_W;
      else                      r = tgt;
    end else begin
      r = tgt;
    end
    return r;
  endfunction

  logic [15:0] pwm_cnt_q, pwm_cnt_d;
  logic [15:0] act_l_q, act_l_d;
  logic [15:0] act_r_q, act_r_d;
  logic [15:0] dead_cnt_q, dead_cnt_d;
  logic [2:0]  tgt_mode_q, tgt_mode_d;
  logic [2:0]  mode_q, mode_d;
  logic [0:0]  state_q, state_d;
  logic        dir_l_q, dir_l_d;
  logic        dir_r_q, dir_r_d;
  logic        busy_q, busy_d;
  logic        pwm_l_q, pwm_l_d;
  logic        pwm_r_q, pwm_r_d;

  logic [1:0]  need_dirs;
  logic [15:0] tgt_duty;
  logic        boundary;

  // Next-state logic: decode, dead-time FSM, ramp and PWM compare.
  always_comb begin
    pwm_cnt_d  = (pwm_cnt_q == PERIOD_LAST) ? 16'd0 : pwm_cnt_q + 16'd1;
    tgt_mode_d = decode_cmd(stop, backward, turn_left, turn_right);
    act_l_d    = act_l_q;
    act_r_d    = act_r_q;
    dead_cnt_d = dead_cnt_q;
    mode_d     = mode_q;
    state_d    = state_q;
    dir_l_d    = dir_l_q;
    dir_r_d    = dir_r_q;
    busy_d     = busy_q;
    need_dirs  = mode_dirs(tgt_mode_q, dir_l_q, dir_r_q);
    tgt_duty   = mode_duty(tgt_mode_q);
    boundary   = (pwm_cnt_q == PERIOD_LAST);

    case (state_q)
      ST_RUN: begin
        if (need_dirs != {dir_l_q, dir_r_q}) begin
          // Reversal requested: kill drive now and start coasting.
          state_d    = ST_DEAD;
          dead_cnt_d = DEAD_LOAD;
          busy_d     = 1'b1;
          act_l_d    = 16'd0;
          act_r_d    = 16'd0;
        end else begin
          mode_d = tgt_mode_q;
          if (boundary) begin
            act_l_d = ramp(act_l_q, tgt_duty);
            act_r_d = ramp(act_r_q, tgt_duty);
          end else begin
            act_l_d = act_l_q;
            act_r_d = act_r_q;
          end
        end
      end
      ST_DEAD: begin
        act_l_d = 16'd0;
        act_r_d = 16'd0;
        if (dead_cnt_q == 16'd0) begin
          // Apply whatever is commanded now, not what caused the entry.
          state_d = ST_RUN;
          busy_d  = 1'b0;
          dir_l_d = need_dirs[1];
          dir_r_d = need_dirs[0];
          mode_d  = tgt_mode_q;
        end else begin
          dead_cnt_d = dead_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
        act_l_d = 16'd0;
        act_r_d = 16'd0;
      end
    endcase

    // Compare against next-cycle counter and duty so the registered output
    // lines up with pwm_cnt and drops in the same cycle busy rises.
    pwm_l_d = (pwm_cnt_d < act_l_d);
    pwm_r_d = (pwm_cnt_d < act_r_d);
  end

  // State registers with synchronous reset to a coasting, forward-facing idle.
  always_ff @(posedge clk_1M) begin
    if (rst) begin
      pwm_cnt_q  <= 16'd0;
      act_l_q    <= 16'd0;
      act_r_q    <= 16'd0;
      dead_cnt_q <= 16'd0;
      tgt_mode_q <= MODE_HALT;
      mode_q     <= MODE_HALT;
      state_q    <= ST_RUN;
      dir_l_q    <= 1'b1;
      dir_r_q    <= 1'b1;
      busy_q     <= 1'b0;
      pwm_l_q    <= 1'b0;
      pwm_r_q    <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      act_l_q    <= act_l_d;
      act_r_q    <= act_r_d;
      dead_cnt_q <= dead_cnt_d;
      tgt_mode_q <= tgt_mode_d;
      mode_q     <= mode_d;
      state_q    <= state_d;
      dir_l_q    <= dir_l_d;
      dir_r_q    <= dir_r_d;
      busy_q     <= busy_d;
      pwm_l_q    <= pwm_l_d;
      pwm_r_q    <= pwm_r_d;
    end
  end

  assign pwm_l = pwm_l_q;
  assign pwm_r = pwm_r_q;
  assign dir_l = dir_l_q;
  assign dir_r = dir_r_q;
  assign mode  = mode_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_motor_drive.sv
// -----------------------------------------------------------------------------
// tb_motor_drive
//
// Drives motor_drive with scaled-down timing (100-cycle period, 200-cycle
// dead-time). A behavioural model queues the expected outputs every clock;
// they are popped and compared on the falling edge. Directed checks against
// fixed values cover latency, ramp profile, dead-time length and reset.
// -----------------------------------------------------------------------------
module tb_motor_drive;

  localparam int TP    = 100;
  localparam int TFWD  = 70;
  localparam int TBACK = 50;
  localparam int TTURN = 65;
  localparam int TSTEP = 10;
  localparam int TDEAD = 200;

  localparam logic [15:0] P_LAST = 16'(TP - 1);
  localparam logic [15:0] DEAD_W = 16'(TDEAD);

  logic       clk;
  logic       rst, stop, backward, turn_left, turn_right;
  logic       pwm_l, pwm_r, dir_l, dir_r, busy;
  logic [2:0] mode;

  int n_checks = 0;
  int n_pass   = 0;
  int phase    = 0;

  motor_drive #(
    .PWM_PERIOD(TP), .DUTY_FWD(TFWD), .DUTY_BACK(TBACK),
    .DUTY_TURN(TTURN), .RAMP_STEP(TSTEP), .DEAD_TIME(TDEAD)
  ) dut (
    .clk_1M(clk), .rst(rst), .stop(stop), .backward(backward),
    .turn_left(turn_left), .turn_right(turn_right),
    .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
    .mode(mode), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  typedef struct packed {
    logic [15:0] cnt;
    logic [15:0] al;
    logic [15:0] ar;
    logic [2:0]  tgt;
    logic [2:0]  mode;
    logic        dl;
    logic        dr;
    logic [15:0] dead;   // cycles of coasting still owed, busy = dead != 0
    logic        pl;
    logic        pr;
  } mstate_t;

  mstate_t    m_s;
  logic [7:0] exp_q[$];

  function automatic logic [15:0] goal_of(input logic [2:0] m);
    if (m == 3'd1)                    return 16'(TFWD);
    else if (m == 3'd2)               return 16'(TBACK);
    else if (m == 3'd3 || m == 3'd4)  return 16'(TTURN);
    else                              return 16'd0;
  endfunction

  function automatic logic [15:0] step_to(input logic [15:0] a, input logic [15:0] g);
    int s;
    s = int'(a) + TSTEP;
    if (a >= g)       return g;
    else if (s > int'(g)) return g;
    else              return 16'(s);
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic r, input logic st,
                                         input logic bk, input logic tl, input logic tr);
    mstate_t n;
    logic wl, wr;
    logic [15:0] g;
    n = '0;
    if (r) begin
      n.dl = 1'b1;
      n.dr = 1'b1;
      return n;
    end
    n = s;
    n.cnt = (s.cnt == P_LAST) ? 16'd0 : s.cnt + 16'd1;
    if (st)            n.tgt = bk ? 3'd2 : 3'd0;
    else if (tl && tr) n.tgt = 3'd0;
    else if (tl)       n.tgt = 3'd3;
    else if (tr)       n.tgt = 3'd4;
    else               n.tgt = 3'd1;
    case (s.tgt)
      3'd1:    begin wl = 1'b1; wr = 1'b1; end
      3'd2:    begin wl = 1'b0; wr = 1'b0; end
      3'd3:    begin wl = 1'b0; wr = 1'b1; end
      3'd4:    begin wl = 1'b1; wr = 1'b0; end
      default: begin wl = s.dl; wr = s.dr; end
    endcase
    if (s.dead != 16'd0) begin
      n.al = 16'd0;
      n.ar = 16'd0;
      n.dead = s.dead - 16'd1;
      if (s.dead == 16'd1) begin
        n.dl = wl;
        n.dr = wr;
        n.mode = s.tgt;
      end
    end else if (wl != s.dl || wr != s.dr) begin
      n.dead = DEAD_W;
      n.al = 16'd0;
      n.ar = 16'd0;
    end else begin
      n.mode = s.tgt;
      g = goal_of(s.tgt);
      if (s.cnt == P_LAST) begin
        n.al = step_to(s.al, g);
        n.ar = step_to(s.ar, g);
      end
    end
    n.pl = (n.cnt < n.al);
    n.pr = (n.cnt < n.ar);
    return n;
  endfunction

  function automatic logic [7:0] outs_of(input mstate_t s);
    return {s.pl, s.pr, s.dl, s.dr, s.mode, (s.dead != 16'd0)};
  endfunction

  // Advance the model on each clock and queue the outputs it predicts.
  always @(posedge clk) begin
    exp_q.push_back(outs_of(model_next(m_s, rst, stop, backward, turn_left, turn_right)));
    m_s <= model_next(m_s, rst, stop, backward, turn_left, turn_right);
  end

  // Free-running phase reference, expected to track the DUT period counter.
  always @(posedge clk) begin
    if (rst) phase <= 0;
    else     phase <= (phase == TP - 1) ? 0 : phase + 1;
  end

  // Pop and compare one predicted output vector per cycle.
  always @(negedge clk) begin
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outs", {24'd0, pwm_l, pwm_r, dir_l, dir_r, mode, busy}, {24'd0, e});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_phase0();
    int g;
    g = 0;
    while (phase != 0 && g < TP + 2) begin
      tick(1);
      g++;
    end
    if (phase != 0) check("phase_sync", 32'(phase), 32'd0);
  endtask

  task automatic measure_period(output int hl, output int hr);
    wait_phase0();
    hl = 0;
    hr = 0;
    repeat (TP) begin
      hl += int'(pwm_l);
      hr += int'(pwm_r);
      tick(1);
    end
  endtask

  task automatic measure_busy(output int len, output int bad);
    len = 0;
    bad = 0;
    while (busy === 1'b1 && len < 4 * TDEAD) begin
      len++;
      if (pwm_l !== 1'b0 || pwm_r !== 1'b0) bad++;
      tick(1);
    end
  endtask

  task automatic check_ramp(input string tag, input int goal, input int periods);
    int hl, hr, e;
    for (int k = 1; k <= periods; k++) begin
      measure_period(hl, hr);
      e = (k * TSTEP > goal) ? goal : k * TSTEP;
      check({tag, "_l"}, 32'(hl), 32'(e));
      check({tag, "_r"}, 32'(hr), 32'(e));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hl, hr, len, bad, rest;
    rst = 1'b1; stop = 1'b0; backward = 1'b0; turn_left = 1'b0; turn_right = 1'b0;
    tick(2);
    check("rst_pwm",  {30'd0, pwm_l, pwm_r}, 32'd0);
    check("rst_dir",  {30'd0, dir_l, dir_r}, 32'd3);
    check("rst_mode", {29'd0, mode}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Reset -> FORWARD: two-cycle latency, then ramp 10..70.
    rst = 1'b0;
    tick(1);
    check("fwd_lat1", {29'd0, mode}, 32'd0);
    tick(1);
    check("fwd_lat2", {29'd0, mode}, 32'd1);
    check_ramp("fwd_ramp", TFWD, 8);

    // FORWARD -> stop: HALT immediately, no dead-time, pwm off next period.
    stop = 1'b1;
    tick(2);
    check("halt_mode", {29'd0, mode}, 32'd0);
    check("halt_busy", {31'd0, busy}, 32'd0);
    measure_period(hl, hr);
    check("halt_pwm", 32'(hl + hr), 32'd0);
    check("halt_dir", {30'd0, dir_l, dir_r}, 32'd3);

    // Back to steady FORWARD, then REVERSE with a full dead-time.
    stop = 1'b0;
    tick(8 * TP);
    wait_phase0();
    stop = 1'b1; backward = 1'b1;
    tick(1);
    check("rev_busy_lat1", {31'd0, busy}, 32'd0);
    tick(1);
    check("rev_busy_lat2", {31'd0, busy}, 32'd1);
    measure_busy(len, bad);
    check("rev_dead_len", 32'(len), 32'(TDEAD));
    check("rev_dead_pwm", 32'(bad), 32'd0);
    check("rev_dir", {30'd0, dir_l, dir_r}, 32'd0);
    check("rev_mode", {29'd0, mode}, 32'd2);
    check_ramp("rev_ramp", TBACK, 6);

    // FORWARD again, then LEFT pivot; duty saturates at 65.
    stop = 1'b0; backward = 1'b0;
    tick(TDEAD + 8 * TP);
    wait_phase0();
    turn_left = 1'b1;
    tick(2);
    check("left_busy", {31'd0, busy}, 32'd1);
    measure_busy(len, bad);
    check("left_dead_len", 32'(len), 32'(TDEAD));
    check("left_dir", {30'd0, dir_l, dir_r}, 32'd1);
    check("left_mode", {29'd0, mode}, 32'd3);
    check_ramp("left_ramp", TTURN, 8);

    // FORWARD -> REVERSE, redirected to RIGHT part-way through DEAD.
    turn_left = 1'b0;
    tick(TDEAD + 8 * TP);
    wait_phase0();
    stop = 1'b1; backward = 1'b1;
    tick(2);
    check("redir_busy", {31'd0, busy}, 32'd1);
    len = 0;
    repeat (50) begin
      if (busy === 1'b1) len++;
      tick(1);
    end
    stop = 1'b0; backward = 1'b0; turn_right = 1'b1;
    measure_busy(rest, bad);
    check("redir_dead_len", 32'(len + rest), 32'(TDEAD));
    check("redir_dir", {30'd0, dir_l, dir_r}, 32'd2);
    check("redir_mode", {29'd0, mode}, 32'd4);

    // stop overrides turns: HALT without dead-time.
    tick(3 * TP);
    stop = 1'b1; turn_left = 1'b1;
    tick(2);
    check("stopturn_mode", {29'd0, mode}, 32'd0);
    tick(20);
    check("stopturn_busy", {31'd0, busy}, 32'd0);
    check("stopturn_dir", {30'd0, dir_l, dir_r}, 32'd2);

    // Both turns from RIGHT: HALT.
    stop = 1'b0; turn_left = 1'b0;
    tick(3);
    check("right_mode", {29'd0, mode}, 32'd4);
    turn_left = 1'b1;
    tick(2);
    check("both_mode", {29'd0, mode}, 32'd0);
    check("both_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a dead-time.
    turn_left = 1'b0; turn_right = 1'b0;
    tick(2);
    check("mid_busy", {31'd0, busy}, 32'd1);
    tick(TDEAD / 2);
    rst = 1'b1;
    tick(1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_dir",  {30'd0, dir_l, dir_r}, 32'd3);
    check("mid_rst_mode", {29'd0, mode}, 32'd0);
    check("mid_rst_pwm",  {30'd0, pwm_l, pwm_r}, 32'd0);
    rst = 1'b0;
    tick(3);
    check("post_rst_mode", {29'd0, mode}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
